// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Imported by instr_fetch and its jump LUT.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_RUN,
        F_HALT
    } fetch_state;

    // mov r2,r2: architecturally a no-op
    localparam logic [8:0] BUBBLE_INSTR = 9'h022;

endpackage

// File: rtl/instr_fetch_jump_lut.sv
// Four-entry jump target table for ljp0..3.
// Registered write port, combinational read port.
module jump_lut #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [1:0]   widx,
    input  logic [W-1:0] wdata,
    input  logic [1:0]   ridx,
    output logic [W-1:0] rdata
);

    logic [W-1:0] tbl [4];

    // table update; a same-cycle read sees the pre-write value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) tbl[i] <= '0;
        end else if (we) begin
            tbl[widx] <= wdata;
        end
    end

    assign rdata = tbl[ridx];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, sync imem addressing, redirects,
// start/done run control with a 1-cycle redirect bubble.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               PC_W     = 10,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int               OFF_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             done,
    input  logic             stall,
    input  logic             br_abs,
    input  logic [PC_W-1:0]  br_addr,
    input  logic             br_rel,
    input  logic [OFF_W-1:0] br_off,
    input  logic             ljp_en,
    input  logic [1:0]       ljp_idx,
    input  logic             lut_we,
    input  logic [1:0]       lut_widx,
    input  logic [PC_W-1:0]  lut_wdata,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [8:0]       imem_rdata,
    output logic [8:0]       instr,
    output logic             instr_valid,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             halted
);

    fetch_state      state;
    logic            squash;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] lut_tgt;
    logic [PC_W-1:0] rel_tgt;
    logic [PC_W-1:0] target;
    logic            redirect;

    jump_lut #(.W(PC_W)) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lut_we),
        .widx  (lut_widx),
        .wdata (lut_wdata),
        .ridx  (ljp_idx),
        .rdata (lut_tgt)
    );

    assign pc_inc  = pc + PC_W'(1);
    assign rel_tgt = pc + {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};

    // re-read pc when not advancing so rdata stays coherent
    assign imem_addr = (state != F_RUN || squash || stall) ? pc : pc_inc;

    assign instr_valid = (state == F_RUN) && !squash;
    assign instr       = instr_valid ? imem_rdata : BUBBLE_INSTR;
    assign running     = (state == F_RUN);
    assign halted      = (state == F_HALT);

    // redirect target select: abs beats lut beats rel
    always_comb begin
        redirect = br_abs || ljp_en || br_rel;
        target   = rel_tgt;
        if (br_abs)      target = br_addr;
        else if (ljp_en) target = lut_tgt;
    end

    // run-control FSM with pc and squash tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= F_IDLE;
            pc     <= RESET_PC;
            squash <= 1'b0;
        end else begin
            unique case (state)
                F_IDLE: begin
                    if (start) begin
                        state  <= F_RUN;
                        squash <= 1'b0;
                    end
                end
                F_RUN: begin
                    if (squash) begin
                        if (!stall) squash <= 1'b0;
                    end else if (!stall) begin
                        if (done) begin
                            state <= F_HALT;
                        end else if (redirect) begin
                            pc     <= target;
                            squash <= 1'b1;
                        end else begin
                            pc     <= pc_inc;
                            squash <= 1'b0;
                        end
                    end
                end
                F_HALT: begin
                    if (start) begin
                        state  <= F_RUN;
                        pc     <= RESET_PC;
                        squash <= 1'b1;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle
// synchronous imem model holding mem[n] = n[8:0].
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic       stall = 1'b0;
    logic       br_abs = 1'b0;
    logic [9:0] br_addr = '0;
    logic       br_rel = 1'b0;
    logic [7:0] br_off = '0;
    logic       ljp_en = 1'b0;
    logic [1:0] ljp_idx = '0;
    logic       lut_we = 1'b0;
    logic [1:0] lut_widx = '0;
    logic [9:0] lut_wdata = '0;
    logic [9:0] imem_addr;
    logic [8:0] imem_rdata = '0;
    logic [8:0] instr;
    logic       instr_valid;
    logic [9:0] pc;
    logic       running;
    logic       halted;

    logic [8:0] mem [1024];

    int checks = 0;
    int failures = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .done        (done),
        .stall       (stall),
        .br_abs      (br_abs),
        .br_addr     (br_addr),
        .br_rel      (br_rel),
        .br_off      (br_off),
        .ljp_en      (ljp_en),
        .ljp_idx     (ljp_idx),
        .lut_we      (lut_we),
        .lut_widx    (lut_widx),
        .lut_wdata   (lut_wdata),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .running     (running),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic v,
                             input logic [9:0] p, input logic [8:0] ins);
        chk({tag, ".valid"}, 16'(instr_valid), 16'(v));
        chk({tag, ".pc"}, 16'(pc), 16'(p));
        chk({tag, ".instr"}, 16'(instr), 16'(ins));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'(i);

        #2 rst_n = 1'b0;
        #1;
        chk("rst.instr", 16'(instr), 16'h022);
        chk("rst.valid", 16'(instr_valid), 16'h0);
        chk("rst.running", 16'(running), 16'h0);
        chk("rst.halted", 16'(halted), 16'h0);
        chk("rst.imem_addr", 16'(imem_addr), 16'h000);
        chk("rst.pc", 16'(pc), 16'h000);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle.running", 16'(running), 16'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run.running", 16'(running), 16'h1);

        // sequential fetch 0..5 with no gaps
        for (int n = 0; n < 5; n++) begin
            chk_fetch("seq", 1'b1, 10'(n), 9'(n));
            step();
        end
        chk_fetch("seq5", 1'b1, 10'h005, 9'h005);

        // absolute jump to 0x40
        br_abs = 1'b1;
        br_addr = 10'h040;
        step();
        br_abs = 1'b0;
        chk("abs.bubble.valid", 16'(instr_valid), 16'h0);
        chk("abs.bubble.instr", 16'(instr), 16'h022);
        step();
        chk_fetch("abs.tgt", 1'b1, 10'h040, 9'h040);

        // go to pc=2 then relative -3 wraps to 0x3FF
        br_abs = 1'b1;
        br_addr = 10'h002;
        step();
        br_abs = 1'b0;
        step();
        chk_fetch("pc2", 1'b1, 10'h002, 9'h002);
        br_rel = 1'b1;
        br_off = 8'hFD;
        step();
        br_rel = 1'b0;
        chk("rel.bubble.valid", 16'(instr_valid), 16'h0);
        step();
        chk_fetch("rel.wrap", 1'b1, 10'h3FF, 9'h1FF);
        step();
        chk_fetch("seq.wrap", 1'b1, 10'h000, 9'h000);

        // LUT write and ljp to same index: old value 0
        lut_we = 1'b1;
        lut_widx = 2'd2;
        lut_wdata = 10'h123;
        ljp_en = 1'b1;
        ljp_idx = 2'd2;
        step();
        lut_we = 1'b0;
        ljp_en = 1'b0;
        chk("ljp.old.valid", 16'(instr_valid), 16'h0);
        chk("ljp.old.pc", 16'(pc), 16'h000);
        step();
        chk_fetch("ljp.old.tgt", 1'b1, 10'h000, 9'h000);
        ljp_en = 1'b1;
        step();
        ljp_en = 1'b0;
        chk("ljp.new.bubble", 16'(instr_valid), 16'h0);
        step();
        chk_fetch("ljp.new.tgt", 1'b1, 10'h123, 9'h123);

        // stall at pc=7 with a pending abs jump
        br_abs = 1'b1;
        br_addr = 10'h007;
        step();
        step();
        chk_fetch("pc7", 1'b1, 10'h007, 9'h007);
        stall = 1'b1;
        br_addr = 10'h055;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_fetch("stall", 1'b1, 10'h007, 9'h007);
            chk("stall.addr", 16'(imem_addr), 16'h007);
        end
        stall = 1'b0;
        br_abs = 1'b0;
        step();
        chk_fetch("unstall", 1'b1, 10'h008, 9'h008);
        step();
        chk_fetch("pc9", 1'b1, 10'h009, 9'h009);

        // done, with start the same cycle: done wins
        done = 1'b1;
        start = 1'b1;
        step();
        done = 1'b0;
        start = 1'b0;
        chk("halt.halted", 16'(halted), 16'h1);
        chk("halt.running", 16'(running), 16'h0);
        chk_fetch("halt", 1'b0, 10'h009, 9'h022);
        step();
        chk("halt.hold", 16'(halted), 16'h1);

        // restart from HALT: one bubble then RESET_PC
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart.running", 16'(running), 16'h1);
        chk_fetch("restart.bubble", 1'b0, 10'h000, 9'h022);
        step();
        chk_fetch("restart.pc0", 1'b1, 10'h000, 9'h000);
        step();
        chk_fetch("restart.pc1", 1'b1, 10'h001, 9'h001);

        // async reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 16'(instr_valid), 16'h0);
        chk("arst.instr", 16'(instr), 16'h022);
        chk("arst.running", 16'(running), 16'h0);
        chk("arst.halted", 16'(halted), 16'h0);
        chk("arst.pc", 16'(pc), 16'h000);
        chk("arst.addr", 16'(imem_addr), 16'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
